touch_event_ctrl: RTL and testbench
===================================

// Module: touch_event_ctrl
// PURPOSE
// Parametrised successor of the touch wrapper: sits between the I2C touch-register reader and application logic.
// Generates the reader's poll trigger, debounces each of N_POINTS touch channels, and converts raw register
// snapshots into a queued stream of PRESS/MOVE/RELEASE/GESTURE events with valid/ready handshake.
// PARAMETERS
// N_POINTS    2     touch channels tracked (1..4); channel i active in a sample when i < iCOUNT
// XW          10    X coordinate width
// YW          9     Y coordinate width
// DEBOUNCE    2     consecutive samples (1..7) required to confirm press or release
// MOVE_THR    4     MOVE emitted when |dX|>=MOVE_THR or |dY|>=MOVE_THR vs last reported position
// FIFO_DEPTH  8     event queue depth (power of two, >=2)
// POLL_DIV    50000 iCLK cycles between oTRIG pulses
// PORTS
// iCLK        in   1               system clock
// iRSTN       in   1               asynchronous active-low reset
// iEN         in   1               1 = polling enabled
// oTRIG       out  1               one-cycle poll pulse to the register reader
// iREADY      in   1               one-cycle pulse: reader snapshot valid
// iX          in   N_POINTS*XW     packed X, channel 0 in LSBs
// iY          in   N_POINTS*YW     packed Y, channel 0 in LSBs
// iCOUNT      in   3               reported touch count (saturates at N_POINTS)
// iGESTURE    in   8               gesture code, 0 = none
// oEV_VALID   out  1               event available
// iEV_READY   in   1               consumer accepts event when oEV_VALID&iEV_READY
// oEV_TYPE    out  2               0 PRESS, 1 MOVE, 2 RELEASE, 3 GESTURE
// oEV_ID      out  2               channel index (0 for GESTURE)
// oEV_X       out  XW              X (0 for GESTURE)
// oEV_Y       out  YW              Y; for GESTURE low 8 bits = code, upper bits 0
// oDOWN       out  N_POINTS        debounced per-channel touch state
// oBUSY       out  1               snapshot being scanned
// oOVF        out  1               sticky: event dropped on full queue or snapshot dropped while busy
// iCLR_OVF    in   1               synchronous clear of oOVF (set wins if same cycle)
// BEHAVIOUR
// - Reset: all outputs 0, poll counter 0, all channels IDLE, debounce counters 0, queue empty, last gesture 0.
// - Poll: counter runs while iEN=1; oTRIG pulses one cycle when counter reaches POLL_DIV-1, then wraps to 0.
//   iEN=0 holds counter at 0, no oTRIG. First oTRIG exactly POLL_DIV cycles after iEN rises.
// - Scan FSM: IDLE -> LATCH (iREADY=1: register iX/iY/iCOUNT/iGESTURE, oBUSY=1) -> CH (one channel per cycle,
//   0..N_POINTS-1) -> GEST (one cycle) -> IDLE. Scan latency N_POINTS+2 cycles; oBUSY=0 back in IDLE.
//   iREADY while oBUSY=1: snapshot ignored, oOVF set.
// - Per-channel FSM (evaluated in its CH cycle, act = channel active in latched snapshot):
//   UP: act -> PEND_DN (cnt=1; if DEBOUNCE=1 go DOWN immediately, push PRESS).
//   PEND_DN: act -> cnt++; cnt reaches DEBOUNCE -> DOWN, push PRESS with current X/Y, store as last pos;
//            !act -> UP, cnt=0.
//   DOWN: act -> if |X-lastX|>=MOVE_THR or |Y-lastY|>=MOVE_THR push MOVE, update last pos; else no event.
//         !act -> PEND_UP (cnt=1; DEBOUNCE=1 -> UP, push RELEASE).
//   PEND_UP: !act -> cnt++; reaches DEBOUNCE -> UP, push RELEASE with last reported pos; act -> DOWN, cnt=0.
//   oDOWN[i]=1 in DOWN and PEND_UP.
// - Abs diff computed in XW+1 / YW+1 bits, no wrap; iCOUNT>N_POINTS treated as N_POINTS.
// - GEST cycle: push GESTURE when latched code !=0 and != last gesture; last gesture updated every scan.
// - Queue: FIFO_DEPTH entries, first-word-fall-through; oEV_* valid same cycle as oEV_VALID, stable until pop.
//   Push and pop same cycle when full: pop then push, no drop. Push when full without pop: event dropped,
//   channel FSM still advances, oOVF set. Empty: oEV_VALID=0, oEV_* hold last value.
// - Async reset mid-scan or mid-queue: everything returns to reset values, no partial event emitted.
// TESTING
// - Poll: POLL_DIV=10, iEN=1 at cycle 0 -> oTRIG at cycles 10,20,30; drop iEN -> no pulse, counter 0.
// - Press debounce: DEBOUNCE=2, two snapshots iCOUNT=1,X0=100,Y0=50 -> single PRESS id0 (100,50) after 2nd scan,
//   oDOWN=01; glitch of one snapshot iCOUNT=0 in between -> no PRESS.
// - Move/release: from DOWN at (100,50) snapshot (102,51) -> no event; (104,50) -> MOVE (104,50);
//   two snapshots iCOUNT=0 -> RELEASE id0 (104,50), oDOWN=00.
// - Gesture: iGESTURE 0x10,0x10,0x49 -> exactly two GESTURE events, oEV_Y=0x10 then 0x49.
// - Backpressure: iEV_READY=0, generate 10 events with FIFO_DEPTH=8 -> 8 queued, oOVF=1; release ready ->
//   8 events in order; iCLR_OVF -> oOVF=0. iREADY during oBUSY -> snapshot ignored, oOVF=1.
// - Reset: assert iRSTN=0 mid-scan with 3 queued events -> oEV_VALID=0, oDOWN=0, oBUSY=0 next edge.

Source files
------------

// File: rtl/touch_event_ctrl.sv
// touch_event_ctrl
// Sits between an I2C touch-register reader and application logic.
//  - Generates the reader's periodic poll pulse (oTRIG).
//  - Latches each reader snapshot and scans it one channel per cycle.
//  - Debounces every touch channel.
//  - Turns the snapshots into a queued PRESS/MOVE/RELEASE/GESTURE event
//    stream with a valid/ready handshake.
//
// Ports
//   iCLK, iRSTN         clock, asynchronous active-low reset
//   iEN                 polling enable
//   oTRIG               one-cycle poll pulse every POLL_DIV cycles while enabled
//   iREADY              one-cycle pulse: snapshot on iX/iY/iCOUNT/iGESTURE is valid
//   iX, iY              packed per-channel coordinates, channel 0 in the LSBs
//   iCOUNT              reported touch count (values above N_POINTS saturate)
//   iGESTURE            gesture code, 0 = none
//   oEV_VALID/iEV_READY event handshake; an event is consumed when both are 1
//   oEV_TYPE            0 PRESS, 1 MOVE, 2 RELEASE, 3 GESTURE
//   oEV_ID, oEV_X/Y     channel and position (GESTURE: id 0, x 0, y = code)
//   oDOWN               debounced per-channel touch state
//   oBUSY               a snapshot is being scanned
//   oOVF                sticky overflow flag (queue full or snapshot while busy)
//   iCLR_OVF            clears oOVF; a new overflow in the same cycle wins
module touch_event_ctrl #(
  parameter int N_POINTS   = 2,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int DEBOUNCE   = 2,
  parameter int MOVE_THR   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int POLL_DIV   = 50000
) (
  input  logic                   iCLK,
  input  logic                   iRSTN,
  input  logic                   iEN,
  output logic                   oTRIG,
  input  logic                   iREADY,
  input  logic [N_POINTS*XW-1:0] iX,
  input  logic [N_POINTS*YW-1:0] iY,
  input  logic [2:0]             iCOUNT,
  input  logic [7:0]             iGESTURE,
  output logic                   oEV_VALID,
  input  logic                   iEV_READY,
  output logic [1:0]             oEV_TYPE,
  output logic [1:0]             oEV_ID,
  output logic [XW-1:0]          oEV_X,
  output logic [YW-1:0]          oEV_Y,
  output logic [N_POINTS-1:0]    oDOWN,
  output logic                   oBUSY,
  output logic                   oOVF,
  input  logic                   iCLR_OVF
);

  // Event record layout: {type, id, x, y}
  localparam int EW = 4 + XW + YW;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_MOVE    = 2'd1;
  localparam logic [1:0] EV_RELEASE = 2'd2;
  localparam logic [1:0] EV_GESTURE = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_CH, S_GEST} scan_state_t;
  typedef enum logic [1:0] {C_UP, C_PEND_DN, C_DOWN, C_PEND_UP} ch_state_t;

  // ------------------------------------------------------------------
  // Poll trigger
  // ------------------------------------------------------------------
  logic [PW-1:0] poll_cnt_reg;
  logic          trig_reg;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      poll_cnt_reg <= '0;
      trig_reg     <= 1'b0;
    end else if (!iEN) begin
      poll_cnt_reg <= '0;
      trig_reg     <= 1'b0;
    end else if (poll_cnt_reg == PW'(POLL_DIV - 1)) begin
      poll_cnt_reg <= '0;
      trig_reg     <= 1'b1;
    end else begin
      poll_cnt_reg <= poll_cnt_reg + 1'b1;
      trig_reg     <= 1'b0;
    end
  end

  assign oTRIG = trig_reg;

  // ------------------------------------------------------------------
  // Snapshot scan FSM
  // ------------------------------------------------------------------
  scan_state_t            scan_state_reg;
  logic [1:0]             ch_idx_reg;
  logic                   busy_reg;
  logic [N_POINTS*XW-1:0] lat_x_reg;
  logic [N_POINTS*YW-1:0] lat_y_reg;
  logic [2:0]             lat_cnt_reg;
  logic [7:0]             lat_g_reg;
  logic [7:0]             last_g_reg;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      scan_state_reg <= S_IDLE;
      ch_idx_reg     <= '0;
      busy_reg       <= 1'b0;
      lat_x_reg      <= '0;
      lat_y_reg      <= '0;
      lat_cnt_reg    <= '0;
      lat_g_reg      <= '0;
      last_g_reg     <= '0;
    end else begin
      case (scan_state_reg)
        S_IDLE: begin
          if (iREADY) begin
            lat_x_reg      <= iX;
            lat_y_reg      <= iY;
            // Saturate here so every channel compare sees a clean count
            lat_cnt_reg    <= (iCOUNT > 3'(N_POINTS)) ? 3'(N_POINTS) : iCOUNT;
            lat_g_reg      <= iGESTURE;
            scan_state_reg <= S_LATCH;
            busy_reg       <= 1'b1;
          end
        end
        S_LATCH: begin
          ch_idx_reg     <= '0;
          scan_state_reg <= S_CH;
        end
        S_CH: begin
          if (ch_idx_reg == 2'(N_POINTS - 1)) begin
            scan_state_reg <= S_GEST;
          end else begin
            ch_idx_reg <= ch_idx_reg + 2'd1;
          end
        end
        S_GEST: begin
          last_g_reg     <= lat_g_reg;
          scan_state_reg <= S_IDLE;
          busy_reg       <= 1'b0;
        end
        default: begin
          scan_state_reg <= S_IDLE;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign oBUSY = busy_reg;

  // ------------------------------------------------------------------
  // Per-channel debounce / event FSMs
  // ------------------------------------------------------------------
  logic [N_POINTS-1:0] ch_push;
  logic [EW-1:0]       ch_ev [N_POINTS];

  genvar gi;
  generate
    for (gi = 0; gi < N_POINTS; gi++) begin : g_ch
      ch_state_t     st_reg, st_next;
      logic [2:0]    cnt_reg, cnt_next;
      logic [XW-1:0] lx_reg, lx_next;
      logic [YW-1:0] ly_reg, ly_next;
      logic [XW-1:0] cur_x;
      logic [YW-1:0] cur_y;
      logic [XW:0]   dx;
      logic [YW:0]   dy;
      logic          act, sel, deb_done, moved, push_raw;
      logic [1:0]    ev_type;
      logic [XW-1:0] ev_x;
      logic [YW-1:0] ev_y;

      assign cur_x = lat_x_reg[gi*XW +: XW];
      assign cur_y = lat_y_reg[gi*YW +: YW];
      assign act   = (3'(gi) < lat_cnt_reg);
      assign sel   = (scan_state_reg == S_CH) && (ch_idx_reg == 2'(gi));

      // Differences are one bit wider than the coordinates, so they never wrap
      assign dx = (cur_x >= lx_reg) ? ({1'b0, cur_x} - {1'b0, lx_reg})
                                    : ({1'b0, lx_reg} - {1'b0, cur_x});
      assign dy = (cur_y >= ly_reg) ? ({1'b0, cur_y} - {1'b0, ly_reg})
                                    : ({1'b0, ly_reg} - {1'b0, cur_y});
      assign moved = (dx >= (XW+1)'(MOVE_THR)) || (dy >= (YW+1)'(MOVE_THR));

      // cnt is 0 in UP and DOWN, so this same test also covers the
      // DEBOUNCE=1 case where the first sample already confirms the change.
      assign deb_done = ({1'b0, cnt_reg} + 4'd1) >= 4'(DEBOUNCE);

      always_comb begin
        st_next  = st_reg;
        cnt_next = cnt_reg;
        lx_next  = lx_reg;
        ly_next  = ly_reg;
        push_raw = 1'b0;
        ev_type  = EV_PRESS;
        ev_x     = cur_x;
        ev_y     = cur_y;
        case (st_reg)
          C_UP, C_PEND_DN: begin
            if (act) begin
              if (deb_done) begin
                st_next  = C_DOWN;
                cnt_next = '0;
                lx_next  = cur_x;
                ly_next  = cur_y;
                push_raw = 1'b1;
                ev_type  = EV_PRESS;
              end else begin
                st_next  = C_PEND_DN;
                cnt_next = cnt_reg + 3'd1;
              end
            end else begin
              st_next  = C_UP;
              cnt_next = '0;
            end
          end
          C_DOWN, C_PEND_UP: begin
            if (!act) begin
              if (deb_done) begin
                st_next  = C_UP;
                cnt_next = '0;
                push_raw = 1'b1;
                ev_type  = EV_RELEASE;
                ev_x     = lx_reg;
                ev_y     = ly_reg;
              end else begin
                st_next  = C_PEND_UP;
                cnt_next = cnt_reg + 3'd1;
              end
            end else if (st_reg == C_PEND_UP) begin
              // Release glitch: back to DOWN without a movement check
              st_next  = C_DOWN;
              cnt_next = '0;
            end else if (moved) begin
              lx_next  = cur_x;
              ly_next  = cur_y;
              push_raw = 1'b1;
              ev_type  = EV_MOVE;
            end
          end
          default: begin
            st_next  = C_UP;
            cnt_next = '0;
          end
        endcase
      end

      always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
          st_reg  <= C_UP;
          cnt_reg <= '0;
          lx_reg  <= '0;
          ly_reg  <= '0;
        end else if (sel) begin
          st_reg  <= st_next;
          cnt_reg <= cnt_next;
          lx_reg  <= lx_next;
          ly_reg  <= ly_next;
        end
      end

      assign ch_push[gi] = sel & push_raw;
      assign ch_ev[gi]   = {ev_type, 2'(gi), ev_x, ev_y};
      assign oDOWN[gi]   = (st_reg == C_DOWN) || (st_reg == C_PEND_UP);
    end
  endgenerate

  // ------------------------------------------------------------------
  // Event source merge: at most one channel scans per cycle, and the
  // gesture stage never overlaps a channel cycle.
  // ------------------------------------------------------------------
  logic          gest_push;
  logic          push;
  logic [EW-1:0] ev_in;

  assign gest_push = (scan_state_reg == S_GEST) && (lat_g_reg != 8'd0) &&
                     (lat_g_reg != last_g_reg);

  always_comb begin
    push  = gest_push;
    ev_in = {EV_GESTURE, 2'd0, {XW{1'b0}}, YW'(lat_g_reg)};
    for (int i = 0; i < N_POINTS; i++) begin
      if (ch_push[i]) begin
        push  = 1'b1;
        ev_in = ch_ev[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Event queue, first-word-fall-through. head_reg always holds the
  // oldest entry and keeps the last popped entry when the queue empties.
  // ------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [EW-1:0] head_reg, head_next;
  logic          valid_reg;
  logic          ovf_reg;
  logic          pop, full, wr_en, drop, ovf_set;

  assign pop     = valid_reg & iEV_READY;
  assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign wr_en   = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign ovf_set = drop | (iREADY & busy_reg);

  always_comb begin
    count_next = count_reg;
    if (wr_en && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !wr_en) begin
      count_next = count_reg - 1'b1;
    end

    head_next = head_reg;
    if (wr_en && ((count_reg == '0) || (pop && (count_reg == (AW+1)'(1))))) begin
      head_next = ev_in;
    end else if (pop && (count_reg > (AW+1)'(1))) begin
      head_next = mem[rd_ptr_reg + 1'b1];
    end
  end

  // Storage is never observed before it is written, so it needs no reset
  always_ff @(posedge iCLK) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= ev_in;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      valid_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      head_reg  <= head_next;
      valid_reg <= (count_next != '0);
      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end else if (iCLR_OVF) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign oEV_VALID = valid_reg;
  assign oEV_TYPE  = head_reg[EW-1 -: 2];
  assign oEV_ID    = head_reg[EW-3 -: 2];
  assign oEV_X     = head_reg[YW +: XW];
  assign oEV_Y     = head_reg[YW-1:0];
  assign oOVF      = ovf_reg;

endmodule

// File: tb/tb_touch_event_ctrl.sv
// Directed bench for touch_event_ctrl (N_POINTS=2, XW=10, YW=9,
// DEBOUNCE=2, MOVE_THR=4, FIFO_DEPTH=8, POLL_DIV=10).
module tb_touch_event_ctrl;

  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        trig;
  logic        ready = 1'b0;
  logic [19:0] x = '0;
  logic [17:0] y = '0;
  logic [2:0]  count = '0;
  logic [7:0]  gesture = '0;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [1:0]  ev_type;
  logic [1:0]  ev_id;
  logic [9:0]  ev_x;
  logic [8:0]  ev_y;
  logic [1:0]  down;
  logic        busy;
  logic        ovf;
  logic        clr_ovf = 1'b0;

  int errors = 0;
  int checks = 0;

  touch_event_ctrl #(
    .N_POINTS(NP), .XW(10), .YW(9), .DEBOUNCE(2), .MOVE_THR(4),
    .FIFO_DEPTH(8), .POLL_DIV(10)
  ) dut (
    .iCLK(clk), .iRSTN(rst_n), .iEN(en), .oTRIG(trig), .iREADY(ready),
    .iX(x), .iY(y), .iCOUNT(count), .iGESTURE(gesture),
    .oEV_VALID(ev_valid), .iEV_READY(ev_ready), .oEV_TYPE(ev_type),
    .oEV_ID(ev_id), .oEV_X(ev_x), .oEV_Y(ev_y), .oDOWN(down),
    .oBUSY(busy), .oOVF(ovf), .iCLR_OVF(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] t;
    logic [1:0] id;
    logic [9:0] x;
    logic [8:0] y;
  } ev_t;

  typedef struct {
    logic [2:0] cnt;
    logic [9:0] x0;
    logic [8:0] y0;
    logic [9:0] x1;
    logic [8:0] y1;
    logic [7:0] g;
    int         n;
    logic [1:0] down;
    ev_t        e0;
    ev_t        e1;
  } vec_t;

  localparam ev_t NO = '0;

  function automatic ev_t mke(input int t, input int id, input int ex, input int ey);
    ev_t e;
    e.t  = 2'(t);
    e.id = 2'(id);
    e.x  = 10'(ex);
    e.y  = 9'(ey);
    return e;
  endfunction

  function automatic vec_t mkv(input int c, input int x0, input int y0, input int x1,
                               input int y1, input int g, input int n, input int dn,
                               input ev_t e0, input ev_t e1);
    vec_t v;
    v.cnt = 3'(c);   v.x0 = 10'(x0); v.y0 = 9'(y0);
    v.x1  = 10'(x1); v.y1 = 9'(y1);  v.g  = 8'(g);
    v.n   = n;       v.down = 2'(dn); v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one snapshot and wait until the scan is complete
  task automatic snap(input logic [2:0] c, input logic [9:0] x0, input logic [8:0] y0,
                      input logic [9:0] x1, input logic [8:0] y1, input logic [7:0] g);
    @(negedge clk);
    ready = 1'b1; count = c; x = {x1, x0}; y = {y1, y0}; gesture = g;
    @(negedge clk);
    ready = 1'b0;
    repeat (NP + 3) @(negedge clk);
    $display("snap cnt=%0d p0=(%0d,%0d) p1=(%0d,%0d) g=0x%0h -> down=%b valid=%0d",
             c, x0, y0, x1, y1, g, down, ev_valid);
  endtask

  task automatic pop_one();
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  task automatic expect_ev(input string name, input ev_t e);
    $display("pop %s type=%0d id=%0d x=%0d y=%0d valid=%0d", name, ev_type, ev_id, ev_x, ev_y, ev_valid);
    chk({name, ".valid"}, 32'(ev_valid), 32'd1);
    chk({name, ".type"},  32'(ev_type),  32'(e.t));
    chk({name, ".id"},    32'(ev_id),    32'(e.id));
    chk({name, ".x"},     32'(ev_x),     32'(e.x));
    chk({name, ".y"},     32'(ev_y),     32'(e.y));
    pop_one();
  endtask

  vec_t vec [19];

  initial begin
    // Channel-level vectors (each snapshot yields at most two events)
    vec[0]  = mkv(1, 100, 50, 0, 0, 8'h00, 0, 0, NO, NO);                          // pend press
    vec[1]  = mkv(0, 0, 0, 0, 0, 8'h00, 0, 0, NO, NO);                             // glitch -> UP
    vec[2]  = mkv(1, 100, 50, 0, 0, 8'h00, 0, 0, NO, NO);
    vec[3]  = mkv(1, 100, 50, 0, 0, 8'h00, 1, 1, mke(0, 0, 100, 50), NO);          // PRESS
    vec[4]  = mkv(1, 102, 51, 0, 0, 8'h00, 0, 1, NO, NO);                          // below thr
    vec[5]  = mkv(1, 104, 50, 0, 0, 8'h00, 1, 1, mke(1, 0, 104, 50), NO);          // MOVE
    vec[6]  = mkv(0, 0, 0, 0, 0, 8'h00, 0, 1, NO, NO);                             // pend release
    vec[7]  = mkv(0, 0, 0, 0, 0, 8'h00, 1, 0, mke(2, 0, 104, 50), NO);             // RELEASE
    vec[8]  = mkv(0, 0, 0, 0, 0, 8'h10, 1, 0, mke(3, 0, 0, 8'h10), NO);            // GESTURE
    vec[9]  = mkv(0, 0, 0, 0, 0, 8'h10, 0, 0, NO, NO);                             // repeat code
    vec[10] = mkv(0, 0, 0, 0, 0, 8'h49, 1, 0, mke(3, 0, 0, 8'h49), NO);
    vec[11] = mkv(2, 5, 6, 200, 300, 8'h49, 0, 0, NO, NO);
    vec[12] = mkv(2, 5, 6, 200, 300, 8'h49, 2, 3, mke(0, 0, 5, 6), mke(0, 1, 200, 300));
    vec[13] = mkv(3, 5, 6, 200, 310, 8'h49, 1, 3, mke(1, 1, 200, 310), NO);        // count saturates
    vec[14] = mkv(1, 9, 6, 0, 0, 8'h49, 1, 3, mke(1, 0, 9, 6), NO);
    vec[15] = mkv(0, 0, 0, 0, 0, 8'h49, 1, 1, mke(2, 1, 200, 310), NO);
    vec[16] = mkv(1, 9, 6, 0, 0, 8'h49, 0, 1, NO, NO);                             // PEND_UP -> DOWN
    vec[17] = mkv(0, 0, 0, 0, 0, 8'h49, 0, 1, NO, NO);
    vec[18] = mkv(0, 0, 0, 0, 0, 8'h49, 1, 0, mke(2, 0, 9, 6), NO);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.trig", 32'(trig), 0);
    chk("rst.valid", 32'(ev_valid), 0);
    chk("rst.down", 32'(down), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.ovf", 32'(ovf), 0);
    chk("rst.ev", {8'd0, ev_type, ev_id, ev_x, ev_y}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Poll trigger: pulses 10, 20, 30 cycles after enable
    en = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      chk($sformatf("poll.c%0d", k), 32'(trig), (k % 10 == 0) ? 1 : 0);
    end
    en = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("poll_off.c%0d", k), 32'(trig), 0);
    end
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("poll_re.c%0d", k), 32'(trig), (k == 10) ? 1 : 0);
    end
    en = 1'b0;
    $display("poll sequence done");

    // Table-driven channel and gesture vectors
    for (int i = 0; i < 19; i++) begin
      snap(vec[i].cnt, vec[i].x0, vec[i].y0, vec[i].x1, vec[i].y1, vec[i].g);
      chk($sformatf("v%0d.down", i), 32'(down), 32'(vec[i].down));
      if (vec[i].n > 0) expect_ev($sformatf("v%0d.e0", i), vec[i].e0);
      if (vec[i].n > 1) expect_ev($sformatf("v%0d.e1", i), vec[i].e1);
      chk($sformatf("v%0d.empty", i), 32'(ev_valid), 0);
    end

    // Backpressure: fill the queue with gesture events 1..8
    for (int g = 1; g <= 8; g++) snap(3'd0, 10'd0, 9'd0, 10'd0, 9'd0, 8'(g));
    chk("bp.full_ovf", 32'(ovf), 0);
    chk("bp.head", 32'(ev_y), 1);

    // Push of gesture 9 coincides with a pop while full: nothing is lost
    @(negedge clk);
    ready = 1'b1; count = 3'd0; gesture = 8'd9;
    @(negedge clk);
    ready = 1'b0;
    repeat (3) @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    $display("simultaneous push/pop while full: head y=%0d ovf=%0d", ev_y, ovf);
    chk("bp.pushpop_ovf", 32'(ovf), 0);
    chk("bp.pushpop_head", 32'(ev_y), 2);

    // Two more events with the queue full are dropped
    snap(3'd0, 10'd0, 9'd0, 10'd0, 9'd0, 8'd10);
    snap(3'd0, 10'd0, 9'd0, 10'd0, 9'd0, 8'd11);
    chk("bp.drop_ovf", 32'(ovf), 1);
    for (int g = 2; g <= 9; g++) expect_ev($sformatf("bp.ev%0d", g), mke(3, 0, 0, g));
    chk("bp.drained", 32'(ev_valid), 0);
    chk("bp.hold_y", 32'(ev_y), 9);
    chk("bp.hold_type", 32'(ev_type), 3);
    chk("bp.ovf_sticky", 32'(ovf), 1);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("bp.ovf_clr", 32'(ovf), 0);

    // Scan latency and snapshot while busy
    @(negedge clk);
    ready = 1'b1; count = 3'd0; gesture = 8'd11;
    @(negedge clk);
    chk("busy.p0", 32'(busy), 1);
    ready = 1'b1; count = 3'd1; gesture = 8'h55;   // must be ignored
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy.p3", 32'(busy), 1);
    @(negedge clk);
    chk("busy.p4", 32'(busy), 0);
    chk("busy.ovf", 32'(ovf), 1);
    repeat (4) @(negedge clk);
    chk("busy.no_event", 32'(ev_valid), 0);
    chk("busy.no_press", 32'(down), 0);
    $display("busy drop: ovf=%0d valid=%0d", ovf, ev_valid);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;

    // Reset mid-scan with three queued events
    snap(3'd1, 10'd20, 9'd30, 10'd0, 9'd0, 8'h21);
    snap(3'd1, 10'd20, 9'd30, 10'd0, 9'd0, 8'h22);
    chk("rs.pre_valid", 32'(ev_valid), 1);
    chk("rs.pre_down", 32'(down), 1);
    @(negedge clk);
    ready = 1'b1; count = 3'd1; gesture = 8'h23;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    $display("reset mid-scan: valid=%0d down=%b busy=%0d", ev_valid, down, busy);
    chk("rs.valid", 32'(ev_valid), 0);
    chk("rs.down", 32'(down), 0);
    chk("rs.busy", 32'(busy), 0);
    chk("rs.ovf", 32'(ovf), 0);
    chk("rs.ev", {8'd0, ev_type, ev_id, ev_x, ev_y}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // Debounce restarted: one active sample is not a press, gesture 0 is none
    snap(3'd1, 10'd20, 9'd30, 10'd0, 9'd0, 8'h00);
    chk("rs.post_valid", 32'(ev_valid), 0);
    chk("rs.post_down", 32'(down), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
